countdown_timer_6_bit: RTL and testbench
========================================

Name: countdown_timer_6_bit

Overview:
- Loadable down-counting timer: the consuming end of the up-counter chain.
- The up counter measures elapsed ticks; this block takes a tick budget, counts it down, and signals expiry to game control logic.
- Typical use: level/hazard timers driven from the shared clock with a shared enable.
- Status flags let a controller start, monitor and acknowledge the timer.

Parameters:
- WIDTH, 6, bit width of load value and count.
- PRESCALE, 4, number of enabled clk cycles per decrement (legal range 1..256).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- clr  input  1  asynchronous reset, active-low.
- en  input  1  global enable; 0 freezes the prescaler, count and FSM (start/ack still honoured).
- start  input  1  load load_val and begin countdown; sampled every cycle.
- load_val  input  WIDTH  tick budget captured on start.
- ack  input  1  clears done and returns the timer to IDLE.
- count  output  WIDTH  remaining ticks (registered).
- busy  output  1  high in RUN.
- done  output  1  high in DONE, held until ack or start.
- expire  output  1  single-cycle pulse on the first cycle of DONE.

Behaviour:
- Reset (clr=0, async):
  - state=IDLE, count=0, prescaler=0.
  - busy=0, done=0, expire=0.
  - Outputs remain at these values while clr is low; normal operation resumes on the first clk edge after release.
- States: IDLE, RUN, DONE. busy and done decode from state, registered with no combinational path from inputs.
- Priority in every state: start > ack > tick.
- start (any state):
  - load_val != 0: count<=load_val, prescaler<=0, RUN.
  - load_val == 0: count<=0, DONE, expire=1 next cycle.
  - A start in RUN restarts the countdown with no expiry pulse.
- IDLE:
  - Holds count.
  - ack is ignored.
- RUN, when en=1:
  - Prescaler increments each cycle.
  - When prescaler==PRESCALE-1: prescaler<=0 and count<=count-1.
  - If that decrement takes count from 1 to 0, go to DONE.
- RUN, when en=0: prescaler, count and state hold.
- DONE:
  - count=0, done=1.
  - ack=1 -> IDLE with done=0 on the next cycle.
  - en has no effect on DONE.
- expire is high for exactly one cycle, the first cycle in DONE. Re-entering DONE produces a new pulse.
- Latency: start sampled at edge k with en held high and load_val=N>0, so busy=1 from k+1. DONE/expire are visible after edge k+N*PRESCALE.
- Wrap-around: count never underflows and the prescaler never exceeds PRESCALE-1.
- PRESCALE=1: decrement on every enabled cycle; the prescaler register may be optimised away.
- Simultaneous start+ack in DONE: start wins and a new run begins.
- Reset mid-RUN: count and state clear immediately; expire is not pulsed.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - prescaler width function (clog2 of PRESCALE, minimum 1).
- One natural sub-module, timer_prescaler:
  - inputs: clk, clr, en, sync clear.
  - output: one-cycle tick when its count reaches PRESCALE-1.
- The FSM, down-counter and expire register stay in the top module.

Test Plan:
- Reset: hold clr=0 for 3 cycles with start=1 and load_val=6'd9 -> count=0, busy=0, done=0, expire=0 throughout. After release, start produces busy=1 on the next edge.
- Basic run: PRESCALE=4, start with load_val=6'd3 and en=1 -> count goes 3,2,1,0 in steps every 4 cycles. done and expire rise exactly 12 cycles after the start edge; expire lasts 1 cycle and done holds until ack, then IDLE.
- Enable gating:
  - load_val=6'd2 with en dropped for 5 cycles mid-run -> expiry delayed by exactly 5 cycles, count frozen during the gap.
  - In DONE with en=0, ack still returns to IDLE.
- Boundaries:
  - load_val=6'd0 -> DONE and expire on the next cycle, no RUN.
  - load_val=6'd63 -> first decrement to 62 with no overflow; expiry at 252 cycles.
- Restart/priority:
  - start with load_val=6'd5 during RUN at count=2 -> count=5, prescaler=0, no expire.
  - start+ack together in DONE -> RUN with done=0.
- Async reset mid-RUN: assert clr between clock edges at count=4 -> count=0 and busy=0 immediately, with no expire pulse before or after release.

Source files
------------

// File: rtl/countdown_timer_6_bit_pkg.sv
// Shared definitions for the countdown timer.
//   state_t  : FSM state encoding (IDLE / RUN / DONE)
//   presc_w  : width of the prescaler counter for a given PRESCALE
package countdown_timer_6_bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold 0..p-1, never less than one bit.
  function automatic int presc_w(input int p);
    int w;
    w = $clog2(p);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/countdown_timer_6_bit_timer_prescaler.sv
// Prescaler for the countdown timer: counts enabled clock cycles and emits a
// one-cycle tick on the cycle its count sits at PRESCALE-1.
// Ports:
//   clk      : system clock
//   clr      : asynchronous reset, active-low
//   en       : advance the count this cycle
//   sync_clr : synchronous clear back to 0 (wins over en)
//   tick     : high while en=1 and count==PRESCALE-1
module countdown_timer_6_bit_timer_prescaler
  import countdown_timer_6_bit_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int PW = presc_w(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // Tick is decoded from the registered count so the consumer decrements on
  // the same edge at which the prescaler wraps to 0.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/countdown_timer_6_bit.sv
// Loadable down-counting timer. start loads a tick budget, the count drops by
// one every PRESCALE enabled cycles, and reaching zero raises done (held until
// ack or start) plus a one-cycle expire pulse.
// Ports:
//   clk      : system clock
//   clr      : asynchronous reset, active-low
//   en       : global enable, freezes prescaler/count/FSM (start, ack honoured)
//   start    : load load_val and begin counting
//   load_val : tick budget captured on start
//   ack      : acknowledge expiry, DONE -> IDLE
//   count    : remaining ticks
//   busy     : high in RUN
//   done     : high in DONE
//   expire   : pulse on first cycle of DONE
module countdown_timer_6_bit
  import countdown_timer_6_bit_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expire
);

  state_t state;
  logic   tick;

  // The prescaler only runs while counting; a start restarts its phase.
  countdown_timer_6_bit_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .clr      (clr),
    .en       (en && (state == RUN)),
    .sync_clr (start),
    .tick     (tick)
  );

  // busy/done are written alongside the state so they stay registered.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      expire <= 1'b0;
    end else begin
      expire <= 1'b0;
      if (start) begin
        if (load_val != '0) begin
          state <= RUN;
          count <= load_val;
          busy  <= 1'b1;
          done  <= 1'b0;
        end else begin
          // Zero budget expires immediately without passing through RUN.
          state  <= DONE;
          count  <= '0;
          busy   <= 1'b0;
          done   <= 1'b1;
          expire <= 1'b1;
        end
      end else begin
        case (state)
          RUN: begin
            if (tick) begin
              count <= count - WIDTH'(1);
              if (count == WIDTH'(1)) begin
                state  <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
                expire <= 1'b1;
              end
            end
          end
          DONE: begin
            if (ack) begin
              state <= IDLE;
              done  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_6_bit.sv
module tb_countdown_timer_6_bit;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic       start;
  logic [5:0] load_val;
  logic       ack;
  logic [5:0] count;
  logic       busy;
  logic       done;
  logic       expire;

  int checks   = 0;
  int failures = 0;

  countdown_timer_6_bit #(.WIDTH(6), .PRESCALE(P)) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .start    (start),
    .load_val (load_val),
    .ack      (ack),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .expire   (expire)
  );

  always #5 clk = ~clk;

  // Reference model: remaining enabled cycles until expiry; the visible
  // count is that budget expressed in whole prescale periods (rounded up).
  int         m_st;   // 0 idle, 1 run, 2 done
  int         m_rem;
  logic [5:0] m_cnt;
  logic       m_exp;

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_cnt = '0; m_exp = 1'b0;
  endtask

  task automatic model_step();
    if (!clr) begin
      model_reset();
      return;
    end
    m_exp = 1'b0;
    if (start) begin
      if (load_val != 0) begin
        m_st = 1; m_rem = int'(load_val) * P; m_cnt = load_val;
      end else begin
        m_st = 2; m_rem = 0; m_cnt = '0; m_exp = 1'b1;
      end
    end else if (m_st == 1) begin
      if (en) begin
        m_rem--;
        m_cnt = 6'((m_rem + P - 1) / P);
        if (m_rem == 0) begin
          m_st = 2; m_exp = 1'b1;
        end
      end
    end else if (m_st == 2 && ack) begin
      m_st = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [5:0] ec, input logic eb,
                     input logic ed, input logic ex);
    checks++;
    if (count !== ec || busy !== eb || done !== ed || expire !== ex) begin
      failures++;
      $display("FAIL %s: got count=%0d busy=%b done=%b expire=%b, want count=%0d busy=%b done=%b expire=%b",
               nm, count, busy, done, expire, ec, eb, ed, ex);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  // One clock edge: advance the model, then compare against it.
  task automatic cycle(input string nm);
    @(posedge clk);
    model_step();
    #1;
    chk(nm, m_cnt, m_st == 1, m_st == 2, m_exp);
  endtask

  task automatic idle_in();
    start = 1'b0; ack = 1'b0; en = 1'b1; load_val = '0;
  endtask

  task automatic run_until_done(input string nm, input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      cycle(nm);
      n++;
    end
  endtask

  typedef struct {
    logic       st;
    logic [5:0] lv;
    logic       en;
    logic       ack;
    logic [5:0] c;
    logic       b;
    logic       d;
    logic       x;
  } vec_t;

  vec_t tbl[15];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int n2;

    // start, lv, en, ack -> count, busy, done, expire (one edge per row)
    tbl[0]  = '{1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 6'd0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 6'd0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 6'd1, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 6'd0, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 6'd0, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 6'd0, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 6'd0, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 6'd2, 1'b0, 1'b1, 6'd2, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 6'd0, 1'b0, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 6'd5, 1'b1, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 6'd0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0};

    // Reset held with start asserted: everything stays cleared.
    clr = 1'b0; en = 1'b1; start = 1'b1; load_val = 6'd9; ack = 1'b0;
    model_reset();
    #1;
    chk("reset_t0", 6'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("reset_hold");
    clr = 1'b1;
    cycle("start_after_reset");
    chk("start_after_reset_busy", 6'd9, 1'b1, 1'b0, 1'b0);

    // Back to a clean IDLE for the vector table.
    #2 clr = 1'b0;
    model_reset();
    #1 chk("reset_again", 6'd0, 1'b0, 1'b0, 1'b0);
    idle_in();
    cycle("reset_again_hold");
    #3 clr = 1'b1;

    for (int i = 0; i < 15; i++) begin
      start = tbl[i].st; load_val = tbl[i].lv; en = tbl[i].en; ack = tbl[i].ack;
      cycle($sformatf("tbl_model%0d", i));
      chk($sformatf("tbl%0d", i), tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].x);
    end

    // Basic run: 3 ticks at PRESCALE=4 expire 12 edges after start.
    idle_in(); start = 1'b1; load_val = 6'd3;
    cycle("basic_start");
    idle_in();
    run_until_done("basic_run", 40, n);
    chk_int("basic_latency", n, 12);
    chk_int("basic_expire", int'(expire), 1);
    cycle("basic_hold");
    cycle("basic_hold2");
    ack = 1'b1;
    cycle("basic_ack");
    chk_int("basic_idle_done", int'(done), 0);

    // Enable gap of 5 cycles delays expiry by 5.
    idle_in(); start = 1'b1; load_val = 6'd2;
    cycle("gap_start");
    idle_in();
    for (int i = 0; i < 3; i++) cycle("gap_pre");
    en = 1'b0;
    for (int i = 0; i < 5; i++) cycle("gap_frozen");
    chk_int("gap_count_frozen", int'(count), 2);
    en = 1'b1;
    run_until_done("gap_post", 40, n);
    chk_int("gap_latency", 3 + 5 + n, 13);
    en = 1'b0; ack = 1'b1;
    cycle("done_ack_en0");
    chk_int("done_ack_en0_idle", int'(done), 0);

    // Full-scale budget.
    idle_in(); start = 1'b1; load_val = 6'd63;
    cycle("max_start");
    idle_in();
    for (int i = 0; i < 4; i++) cycle("max_first");
    chk_int("max_first_dec", int'(count), 62);
    run_until_done("max_run", 300, n2);
    chk_int("max_latency", 4 + n2, 252);
    ack = 1'b1;
    cycle("max_ack");

    // Restart during RUN at count 2: reload, no expiry.
    idle_in(); start = 1'b1; load_val = 6'd4;
    cycle("restart_start");
    idle_in();
    n = 0;
    while (count != 6'd2 && n < 40) begin cycle("restart_run"); n++; end
    chk_int("restart_reach2", int'(count), 2);
    start = 1'b1; load_val = 6'd5;
    cycle("restart_reload");
    chk("restart_reload_state", 6'd5, 1'b1, 1'b0, 1'b0);
    idle_in();
    for (int i = 0; i < 3; i++) cycle("restart_after");

    // Asynchronous reset mid-run at count 4.
    start = 1'b1; load_val = 6'd6;
    cycle("arst_start");
    idle_in();
    n = 0;
    while (count != 6'd4 && n < 40) begin cycle("arst_run"); n++; end
    chk_int("arst_reach4", int'(count), 4);
    #2 clr = 1'b0;
    model_reset();
    #1 chk("arst_immediate", 6'd0, 1'b0, 1'b0, 1'b0);
    cycle("arst_hold");
    #3 clr = 1'b1;
    for (int i = 0; i < 30; i++) cycle("arst_after");

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      start    = ($urandom_range(15) == 0);
      load_val = ($urandom_range(7) == 0) ? 6'd0 : 6'($urandom_range(12, 1));
      en       = ($urandom_range(3) != 0);
      ack      = ($urandom_range(7) == 0);
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
